// File: rtl/dram_pkg.sv
// Shared types and helpers for the hxd32 data-memory responder.
package dram_pkg;

    localparam int XLEN   = 32;
    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    // Loader sequencing: collect four bytes, then spend one cycle writing the word.
    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_FILL   = 2'd1,
        LD_COMMIT = 2'd2
    } ld_state_t;

    // True when addr lies inside [base, base + span). The span is one bit wider
    // than XLEN so a RAM that covers the whole address space still decodes.
    function automatic logic in_range(input logic [XLEN-1:0] addr,
                                      input logic [XLEN-1:0] base,
                                      input logic [XLEN:0]   span);
        logic [XLEN-1:0] off;
        off = addr - base;
        return ({1'b0, off} < span);
    endfunction

endpackage

// File: rtl/dram_resp_if.sv
// Core data port plus host loader stream of the data-memory responder.
//
// Loader handshake: a byte on ld_data_i transfers at a rising clock edge where
// ld_valid_i and ld_ready_o are both high. ld_ready_o is registered and never
// depends combinationally on ld_valid_i; the host may hold ld_valid_i while
// ready is low and must keep ld_data_i stable until the transfer edge.
// The core port has no handshake: a read is issued every cycle and its data
// appears one cycle later; a write happens whenever the byte enable is non-zero.
interface dram_resp_if;
    import dram_pkg::*;

    logic [XLEN-1:0]  dram_rd_addr_i;
    logic [XLEN-1:0]  dram_rd_data_o;
    logic [XLEN-1:0]  dram_wr_addr_i;
    logic [XLEN-1:0]  dram_wr_data_i;
    logic [LANES-1:0] dram_wr_byte_en_i;
    logic             ld_en_i;
    logic [BYTE_W-1:0] ld_data_i;
    logic             ld_valid_i;
    logic             ld_ready_o;
    logic             ld_done_o;
    logic             bus_fault_o;
    ld_state_t        ld_state_o;   // loader FSM state, for debug and checkers

    // Core and host side.
    modport master (
        output dram_rd_addr_i, dram_wr_addr_i, dram_wr_data_i, dram_wr_byte_en_i,
        output ld_en_i, ld_data_i, ld_valid_i,
        input  dram_rd_data_o, ld_ready_o, ld_done_o, bus_fault_o, ld_state_o
    );

    // Memory side.
    modport slave (
        input  dram_rd_addr_i, dram_wr_addr_i, dram_wr_data_i, dram_wr_byte_en_i,
        input  ld_en_i, ld_data_i, ld_valid_i,
        output dram_rd_data_o, ld_ready_o, ld_done_o, bus_fault_o, ld_state_o
    );

endinterface

// File: rtl/dram_ld_pack.sv
// Loader FSM and byte packer: assembles little-endian bytes into words and
// issues one full-word write per four accepted bytes at consecutive indices.
module dram_ld_pack
    import dram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ld_en_i,
    input  logic [BYTE_W-1:0] ld_data_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    output logic              ld_done_o,
    output logic              wr_en_o,
    output logic [AW-1:0]     wr_idx_o,
    output logic [XLEN-1:0]   wr_data_o,
    output ld_state_t         state_o
);

    ld_state_t                        state_q;
    logic [1:0]                       cnt_q;
    logic [AW-1:0]                    ptr_q;
    logic [LANES-1:0][BYTE_W-1:0]     buf_q;
    logic                             ready_q;
    logic                             done_q;
    logic                             wr_en_q;

    // Loader FSM with registered ready/done/write-enable; the byte buffer is not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (ld_en_i) begin
                        state_q <= LD_FILL;
                        ptr_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end
                end
                LD_FILL: begin
                    if (!ld_en_i) begin
                        // Any partial word in the buffer is simply abandoned.
                        state_q <= LD_IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (ld_valid_i && ready_q) begin
                        buf_q[cnt_q] <= ld_data_i;
                        cnt_q        <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            ready_q <= 1'b0;
                            wr_en_q <= 1'b1;
                            state_q <= LD_COMMIT;
                        end
                    end
                end
                LD_COMMIT: begin
                    // The write is presented this cycle regardless of ld_en_i,
                    // so a load ending here still lands its last full word.
                    wr_en_q <= 1'b0;
                    ptr_q   <= ptr_q + 1'b1;
                    cnt_q   <= '0;
                    if (ld_en_i) begin
                        ready_q <= 1'b1;
                        state_q <= LD_FILL;
                    end else begin
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= LD_IDLE;
                    end
                end
                default: begin
                    state_q <= LD_IDLE;
                    ready_q <= 1'b0;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready_o = ready_q;
    assign ld_done_o  = done_q;
    assign wr_en_o    = wr_en_q;
    assign wr_idx_o   = ptr_q;
    assign wr_data_o  = buf_q;
    assign state_o    = state_q;

endmodule

// File: rtl/dram_resp.sv
// Data-memory responder for the hxd32 core: byte-lane RAM with 1-cycle
// registered reads, per-lane write-first forwarding, a host byte loader and a
// sticky out-of-range fault. Only XLEN = 32 is supported.
module dram_resp
    import dram_pkg::*;
#(
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    dram_resp_if.slave bus
);

    localparam int            AW   = $clog2(DEPTH_WORDS);
    localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH_WORDS) << 2;

    logic [LANES-1:0][BYTE_W-1:0] mem_q [DEPTH_WORDS];

    logic [XLEN-1:0]  rd_off, wr_off;
    logic [AW-1:0]    rd_idx, wr_idx;
    logic             rd_ok, wr_ok;
    logic             core_we;

    logic             ld_wr_en;
    logic [AW-1:0]    ld_wr_idx;
    logic [XLEN-1:0]  ld_wr_data;

    logic [LANES-1:0] w_be;
    logic [AW-1:0]    w_idx;
    logic [LANES-1:0][BYTE_W-1:0] w_data;

    logic [LANES-1:0][BYTE_W-1:0] rd_word_d;
    logic [XLEN-1:0]  rd_data_q;
    logic             fault_q;

    dram_ld_pack #(.AW(AW)) u_ld_pack (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .ld_en_i    (bus.ld_en_i),
        .ld_data_i  (bus.ld_data_i),
        .ld_valid_i (bus.ld_valid_i),
        .ld_ready_o (bus.ld_ready_o),
        .ld_done_o  (bus.ld_done_o),
        .wr_en_o    (ld_wr_en),
        .wr_idx_o   (ld_wr_idx),
        .wr_data_o  (ld_wr_data),
        .state_o    (bus.ld_state_o)
    );

    // Address decode; the low two address bits are dropped by the word shift.
    assign rd_off  = bus.dram_rd_addr_i - BASE_ADDR;
    assign wr_off  = bus.dram_wr_addr_i - BASE_ADDR;
    assign rd_idx  = AW'(rd_off >> 2);
    assign wr_idx  = AW'(wr_off >> 2);
    assign rd_ok   = in_range(bus.dram_rd_addr_i, BASE_ADDR, SPAN);
    assign wr_ok   = in_range(bus.dram_wr_addr_i, BASE_ADDR, SPAN);
    assign core_we = !bus.ld_en_i && (|bus.dram_wr_byte_en_i) && wr_ok;

    // Write source select: a loader commit wins over a core write in the same cycle.
    always_comb begin
        w_be   = '0;
        w_idx  = ld_wr_idx;
        w_data = ld_wr_data;
        if (ld_wr_en) begin
            w_be = '1;
        end else if (core_we) begin
            w_be   = bus.dram_wr_byte_en_i;
            w_idx  = wr_idx;
            w_data = bus.dram_wr_data_i;
        end
    end

    // Byte-lane RAM write; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_be[i]) begin
                mem_q[w_idx][i] <= w_data[i];
            end
        end
    end

    // Per-lane write-first forwarding of a same-cycle write to the read index.
    always_comb begin
        rd_word_d = mem_q[rd_idx];
        for (int i = 0; i < LANES; i++) begin
            if (w_be[i] && (w_idx == rd_idx)) begin
                rd_word_d[i] = w_data[i];
            end
        end
    end

    // Registered read data; zero while loading or when the read is out of range.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (bus.ld_en_i || !rd_ok) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_word_d;
        end
    end

    // Sticky fault on any out-of-range core access outside loader mode.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fault_q <= 1'b0;
        end else if (!bus.ld_en_i && (!rd_ok || ((|bus.dram_wr_byte_en_i) && !wr_ok))) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.dram_rd_data_o = rd_data_q;
    assign bus.bus_fault_o    = fault_q;

endmodule

// File: tb/tb_dram_resp.sv
// Directed bench for dram_resp: core writes/reads, lane writes, forwarding,
// fault, loader streaming, partial words and reset during a load.
module tb_dram_resp;
  import dram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  dram_resp_if bus ();

  dram_resp dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  // count ld_done_o pulses, sampled once per cycle away from the edge
  always @(negedge clk) begin
    if (rst_n && bus.ld_done_o) done_cnt++;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.dram_wr_addr_i    = addr;
    bus.dram_wr_data_i    = data;
    bus.dram_wr_byte_en_i = be;
    tick();
    bus.dram_wr_byte_en_i = 4'h0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.dram_rd_addr_i = addr;
    tick();
    check_vec(tag, bus.dram_rd_data_o, exp);
    bus.dram_rd_addr_i = 32'h0;
  endtask

  task automatic read_from_q(input string tag, input logic [31:0] addr);
    logic [31:0] e;
    e = exp_q.pop_front();
    do_read(tag, addr, e);
  endtask

  // waits (bounded) for ready, then transfers one byte; reports cycles stalled
  task automatic send_byte(input logic [7:0] b, output int stalls);
    stalls = 0;
    while (!bus.ld_ready_o && stalls < 10) begin
      tick();
      stalls++;
    end
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i  = b;
    tick();
    bus.ld_valid_i = 1'b0;
  endtask

  initial begin
    int st;
    int tot;
    logic [7:0] bytes5 [8];
    int stall_exp [8];

    bytes5    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    stall_exp = '{0, 0, 0, 0, 1, 0, 0, 0};

    bus.dram_rd_addr_i    = 32'h0;
    bus.dram_wr_addr_i    = 32'h0;
    bus.dram_wr_data_i    = 32'h0;
    bus.dram_wr_byte_en_i = 4'h0;
    bus.ld_en_i           = 1'b0;
    bus.ld_data_i         = 8'h0;
    bus.ld_valid_i        = 1'b0;

    // reset state
    repeat (3) tick();
    check_vec("rst_rd_data", bus.dram_rd_data_o, 32'h0);
    check_vec("rst_ready", 32'(bus.ld_ready_o), 32'h0);
    check_vec("rst_done", 32'(bus.ld_done_o), 32'h0);
    check_vec("rst_fault", 32'(bus.bus_fault_o), 32'h0);
    check_vec("rst_state", 32'(bus.ld_state_o), 32'(LD_IDLE));
    rst_n = 1'b1;
    tick();

    // 1. word write and read back
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_read("sw_word", 32'h10, 32'hDEADBEEF);

    // 2. single lane write
    do_write(32'h10, 32'h0000_5500, 4'b0010);
    do_read("sb_lane1", 32'h10, 32'hDEAD55EF);
    do_write(32'h13, 32'h7700_0000, 4'b1000);   // low address bits ignored
    do_read("sb_lane3", 32'h10, 32'h77AD55EF);

    // 3. same-cycle forwarding, per lane
    do_write(32'h20, 32'hAAAAAAAA, 4'hF);
    bus.dram_rd_addr_i = 32'h20;
    do_write(32'h20, 32'h12345678, 4'b1100);
    check_vec("fwd_rd", bus.dram_rd_data_o, 32'h1234AAAA);
    do_read("fwd_mem", 32'h20, 32'h1234AAAA);
    check_vec("fault_clear", 32'(bus.bus_fault_o), 32'h0);

    // 4. out-of-range read and write
    do_write(32'h0, 32'hCAFEF00D, 4'hF);
    do_read("oor_rd_zero", 32'h1000, 32'h0);
    check_vec("oor_fault_set", 32'(bus.bus_fault_o), 32'h1);
    do_write(32'h1010, 32'h11111111, 4'hF);
    do_read("oor_wr_dropped", 32'h10, 32'h77AD55EF);
    do_read("oor_word0_kept", 32'h0, 32'hCAFEF00D);
    check_vec("oor_fault_sticky", 32'(bus.bus_fault_o), 32'h1);
    rst_n = 1'b0;
    tick();
    check_vec("oor_fault_rst", 32'(bus.bus_fault_o), 32'h0);
    rst_n = 1'b1;
    tick();

    // 5. full two-word load
    bus.ld_en_i        = 1'b1;
    bus.dram_rd_addr_i = 32'h10;
    tick();
    check_vec("ld_fill_state", 32'(bus.ld_state_o), 32'(LD_FILL));
    check_vec("ld_ready_up", 32'(bus.ld_ready_o), 32'h1);
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes5[i], st);
      check_vec($sformatf("ld_stall_b%0d", i), 32'(st), 32'(stall_exp[i]));
      if (i == 3) begin
        check_vec("ld_ready_low", 32'(bus.ld_ready_o), 32'h0);
        check_vec("ld_commit_state", 32'(bus.ld_state_o), 32'(LD_COMMIT));
        check_vec("ld_rd_zero", bus.dram_rd_data_o, 32'h0);
      end
    end
    check_vec("ld_commit_last", 32'(bus.ld_state_o), 32'(LD_COMMIT));
    bus.ld_en_i        = 1'b0;
    bus.dram_rd_addr_i = 32'h0;
    tick();
    check_vec("ld_done_pulse", 32'(bus.ld_done_o), 32'h1);
    check_vec("ld_idle", 32'(bus.ld_state_o), 32'(LD_IDLE));
    tick();
    check_vec("ld_done_end", 32'(bus.ld_done_o), 32'h0);
    check_vec("ld_done_cnt", 32'(done_cnt), 32'h1);
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    read_from_q("ld_word0", 32'h0);
    read_from_q("ld_word1", 32'h4);

    // 6. partial word is discarded
    bus.ld_en_i = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'h11 + i), st);
      tot += st;
    end
    check_vec("part_stalls", 32'(tot), 32'h1);
    check_vec("part_in_fill", 32'(bus.ld_state_o), 32'(LD_FILL));
    bus.ld_en_i = 1'b0;
    tick();
    check_vec("part_done", 32'(bus.ld_done_o), 32'h1);
    tick();
    check_vec("part_done_cnt", 32'(done_cnt), 32'h2);
    exp_q.push_back(32'h14131211);
    exp_q.push_back(32'h08070605);
    read_from_q("part_word0", 32'h0);
    read_from_q("part_word1", 32'h4);

    // reset in the middle of a fill
    bus.ld_en_i = 1'b1;
    tick();
    send_byte(8'h21, st);
    send_byte(8'h22, st);
    rst_n       = 1'b0;
    bus.ld_en_i = 1'b0;
    tick();
    check_vec("rst_mid_state", 32'(bus.ld_state_o), 32'(LD_IDLE));
    check_vec("rst_mid_ready", 32'(bus.ld_ready_o), 32'h0);
    rst_n = 1'b1;
    tick();
    do_read("rst_mid_word0", 32'h0, 32'h14131211);
    check_vec("rst_mid_done_cnt", 32'(done_cnt), 32'h2);
    check_vec("end_fault", 32'(bus.bus_fault_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
